// File: rtl/freq_meter_mc_if.sv
// rtl/freq_meter_mc_if.sv - result bus of freq_meter_mc (latched counts, flags, strobe, gate)
interface freq_meter_mc_if #(
  parameter int CH_NUM    = 4,
  parameter int DIG_WIDTH = 8
);
  logic [CH_NUM*DIG_WIDTH*4-1:0] freq_o;
  logic [CH_NUM-1:0]             ovf_o;
  logic [1:0]                    gate_sel_o;
  logic                          valid_o;
  logic                          gate_o;

  modport master (output freq_o, output ovf_o, output gate_sel_o, output valid_o, output gate_o);
  modport slave  (input  freq_o, input  ovf_o, input  gate_sel_o, input  valid_o, input  gate_o);
endinterface

// File: rtl/freq_meter_mc.sv
// rtl/freq_meter_mc.sv - multi-channel BCD edge counter over a selectable gate window
// Optional FREQ_METER_HOLD_EN adds hold_i, which suppresses the result update in LOCK.
module freq_meter_mc #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int CH_NUM      = 4,
  parameter int DIG_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] sig_i,
  input  logic [1:0]        gate_sel_i,
`ifdef FREQ_METER_HOLD_EN
  input  logic              hold_i,
`endif
  freq_meter_mc_if.master   res_if
);

  localparam int CW = DIG_WIDTH * 4;
  localparam int GW = $clog2(CLK_FREQ_HZ);
  localparam logic [GW-1:0] LOAD_1S    = GW'(CLK_FREQ_HZ - 1);
  localparam logic [GW-1:0] LOAD_100MS = GW'(CLK_FREQ_HZ / 10 - 1);
  localparam logic [GW-1:0] LOAD_10MS  = GW'(CLK_FREQ_HZ / 100 - 1);
  localparam logic [CW-1:0] ALL_NINES  = {DIG_WIDTH{4'h9}};

  typedef enum logic [1:0] {ST_CLEAR, ST_GATE, ST_LOCK} state_t;

  state_t                              state_q, state_d;
  logic [SYNC_STAGES-1:0][CH_NUM-1:0]  sync_q;
  logic [CH_NUM-1:0]                   prev_q;
  logic [CH_NUM-1:0]                   edge_w;
  logic [GW-1:0]                       gate_cnt_q, gate_cnt_d;
  logic [GW-1:0]                       gate_load;
  logic [1:0]                          gsel_q, gsel_d;
  logic [CH_NUM-1:0][CW-1:0]           cnt_q, cnt_d;
  logic [CH_NUM-1:0]                   ovf_q, ovf_d;
  logic                                lock_upd;
  logic [CH_NUM*CW-1:0]                freq_q;
  logic [CH_NUM-1:0]                   ovf_out_q;
  logic [1:0]                          gsel_out_q;
  logic                                valid_q;

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIG_WIDTH; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Edge pulse appears SYNC_STAGES+1 cycles after the pin changes.
  assign edge_w = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    gate_load = LOAD_1S;
    case (gate_sel_i)
      2'b01:   gate_load = LOAD_100MS;
      2'b10:   gate_load = LOAD_10MS;
      default: gate_load = LOAD_1S;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    gsel_d     = gsel_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    lock_upd   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        cnt_d      = '0;
        ovf_d      = '0;
        gsel_d     = gate_sel_i;
        gate_cnt_d = gate_load;
        state_d    = ST_GATE;
      end
      ST_GATE: begin
        for (int c = 0; c < CH_NUM; c++) begin
          if (edge_w[c]) begin
            if (cnt_q[c] == ALL_NINES) ovf_d[c] = 1'b1;
            else                       cnt_d[c] = bcd_inc(cnt_q[c]);
          end
        end
        if (gate_cnt_q == '0) state_d = ST_LOCK;
        else                  gate_cnt_d = gate_cnt_q - 1'b1;
      end
      ST_LOCK: begin
        state_d = ST_CLEAR;
`ifdef FREQ_METER_HOLD_EN
        lock_upd = ~hold_i;
`else
        lock_upd = 1'b1;
`endif
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      sync_q     <= '0;
      prev_q     <= '0;
      gate_cnt_q <= '0;
      gsel_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= '0;
      freq_q     <= '0;
      ovf_out_q  <= '0;
      gsel_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q     <= sync_q[SYNC_STAGES-1];
      gate_cnt_q <= gate_cnt_d;
      gsel_q     <= gsel_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      valid_q    <= lock_upd;
      if (lock_upd) begin
        freq_q     <= cnt_q;
        ovf_out_q  <= ovf_q;
        gsel_out_q <= gsel_q;
      end
    end
  end

  assign res_if.freq_o     = freq_q;
  assign res_if.ovf_o      = ovf_out_q;
  assign res_if.gate_sel_o = gsel_out_q;
  assign res_if.valid_o    = valid_q;
  assign res_if.gate_o     = (state_q == ST_GATE);

endmodule

// File: tb/tb_freq_meter_mc.sv
// tb/tb_freq_meter_mc.sv - randomized scoreboard bench for freq_meter_mc
module tb_freq_meter_mc;

  localparam int CLK_HZ = 1000;
  localparam int CH     = 4;
  localparam int DW     = 2;
  localparam int SYNC   = 2;
  localparam int FW     = CH * DW * 4;
  localparam int MAXV   = 99;

  typedef struct packed {
    logic [FW-1:0] freq;
    logic [CH-1:0] ovf;
    logic [1:0]    gs;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] sig_i = '0;
  logic [1:0]    gate_sel_i = 2'b00;

  freq_meter_mc_if #(.CH_NUM(CH), .DIG_WIDTH(DW)) res_if ();

  freq_meter_mc #(
    .CLK_FREQ_HZ(CLK_HZ), .CH_NUM(CH), .DIG_WIDTH(DW), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .sig_i(sig_i), .gate_sel_i(gate_sel_i), .res_if(res_if)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  int   cyc = 0;
  int   win_c = 1;
  int   win_n = 0;
  logic [1:0] gs = 2'b00;
  int   cnt [CH];
  int   arr [CH][$];
  int   maxdur [CH];
  int   left [CH];
  int   dur_tab [6] = '{0, 1, 2, 3, 5, 12};
  exp_t sb [$];
  exp_t held = '0;
  logic exp_gate = 1'b0;
  logic exp_valid = 1'b0;

  // Input drivers: random high/low durations of 1..maxdur cycles; 0 means idle low.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        sig_i[c] = 1'b0;
        left[c]  = 0;
      end else if (maxdur[c] == 0) begin
        sig_i[c] = 1'b0;
      end else if (left[c] == 0) begin
        sig_i[c] = ~sig_i[c];
        if (sig_i[c]) arr[c].push_back(cyc + 1 + SYNC);
        left[c] = $urandom_range(maxdur[c] - 1, 0);
      end else begin
        left[c] = left[c] - 1;
      end
    end
  end

  // Reference model: windows of CLEAR, N gate cycles, LOCK; result appears after LOCK.
  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; win_c = 1; win_n = 0;
      for (int c = 0; c < CH; c++) begin arr[c].delete(); cnt[c] = 0; end
      sb.delete();
      exp_gate = 1'b0; exp_valid = 1'b0;
    end else begin
      cyc++;
      exp_valid = 1'b0;
      if (cyc == win_c) begin
        gs    = gate_sel_i;
        win_n = (gs == 2'b01) ? CLK_HZ / 10 : (gs == 2'b10) ? CLK_HZ / 100 : CLK_HZ;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
      end
      for (int c = 0; c < CH; c++) begin
        while (arr[c].size() > 0 && arr[c][0] <= cyc) begin
          if (arr[c][0] == cyc && cyc > win_c && cyc <= win_c + win_n) cnt[c]++;
          void'(arr[c].pop_front());
        end
      end
      if (cyc == win_c + win_n + 1) begin
        exp_t e;
        e = '0;
        e.gs = gs;
        for (int c = 0; c < CH; c++) begin
          int v;
          e.ovf[c] = (cnt[c] > MAXV);
          v = (cnt[c] > MAXV) ? MAXV : cnt[c];
          for (int d = 0; d < DW; d++) begin
            e.freq[c*DW*4 + d*4 +: 4] = 4'(v % 10);
            v = v / 10;
          end
        end
        sb.push_back(e);
        exp_valid = 1'b1;
        win_c = cyc + 1;
      end
      exp_gate = (cyc >= win_c) && (cyc < win_c + win_n);
    end
  end

  // Monitor: checks gate timing, valid timing, result content and output stability.
  always @(negedge clk) begin
    if (rst) begin
      held = '0;
    end else begin
      exp_t got;
      got = {res_if.freq_o, res_if.ovf_o, res_if.gate_sel_o};
      n_cmp++;
      if (res_if.gate_o !== exp_gate) begin
        n_fail++;
        $display("FAIL gate_o at cyc %0d: got %b want %b", cyc, res_if.gate_o, exp_gate);
      end
      if (res_if.valid_o || exp_valid) begin
        n_cmp++;
        if (res_if.valid_o !== exp_valid) begin
          n_fail++;
          $display("FAIL valid_o timing at cyc %0d: got %b want %b", cyc, res_if.valid_o, exp_valid);
        end
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL scoreboard: valid_o with no expected result (got 1 want 0 pending)");
        end else begin
          held = sb.pop_front();
          if (res_if.valid_o) begin
            n_valid++;
            n_cmp++;
            if (got !== held) begin
              n_fail++;
              $display("FAIL result at cyc %0d: got freq=%h ovf=%b gs=%b want freq=%h ovf=%b gs=%b",
                       cyc, got.freq, got.ovf, got.gs, held.freq, held.ovf, held.gs);
            end
          end
        end
      end else begin
        n_cmp++;
        if (got !== held) begin
          n_fail++;
          $display("FAIL output stability at cyc %0d: got %h want %h", cyc, got, held);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    n_cmp++;
    if (res_if.freq_o !== '0 || res_if.ovf_o !== '0 || res_if.gate_sel_o !== 2'b00 ||
        res_if.valid_o !== 1'b0 || res_if.gate_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s outputs: got freq=%h ovf=%b gs=%b valid=%b gate=%b want all 0", tag,
               res_if.freq_o, res_if.ovf_o, res_if.gate_sel_o, res_if.valid_o, res_if.gate_o);
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin maxdur[c] = 0; left[c] = 0; end
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(posedge clk); #2;
    // Directed: 1 s gate with fast channels forces overflow, then idle clears it.
    maxdur = '{1, 2, 0, 3};
    gate_sel_i = 2'b00;
    rst = 1'b0;
    repeat (1010) @(posedge clk); #2;
    maxdur = '{0, 1, 4, 0};
    gate_sel_i = 2'b10;
    repeat (1100) @(posedge clk); #2;
    for (int ph = 0; ph < 22; ph++) begin
      for (int c = 0; c < CH; c++) maxdur[c] = dur_tab[$urandom_range(5, 0)];
      gate_sel_i = 2'($urandom_range(3, 0));
      repeat ($urandom_range(1000, 150)) @(posedge clk);
      #2;
      if (ph == 9) begin
        rst = 1'b1;
        #1 check_zero("mid-window reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
      end
    end
    gate_sel_i = 2'b10;
    repeat (2100) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results want 0", sb.size());
    end
    n_cmp++;
    if (n_valid < 20) begin
      n_fail++;
      $display("FAIL valid count: got %0d want at least 20", n_valid);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_meter_mc.md
Name: freq_meter_mc

Overview:
Multi-channel reciprocal-free frequency meter that runs in a single clock domain and has a selectable gate time. Each of CH_NUM asynchronous input signals is synchronised and edge-detected. Rising edges are counted in BCD over a common gate window, and the results are latched once per measurement cycle. It replaces the single-channel, fixed-1 s, externally-clocked counter arrangement and feeds seg_ctrl or a host readout directly.

Parameters:
CLK_FREQ_HZ, 27000000, system clock frequency in Hz; must be divisible by 100.
CH_NUM, 4, number of measured input channels (1..8).
DIG_WIDTH, 8, BCD digits per channel result (1..9).
SYNC_STAGES, 2, synchroniser flops per input (>=2).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sig_i  in  CH_NUM  asynchronous signals to measure
gate_sel_i  in  2  gate time select: 00=1 s, 01=100 ms, 10=10 ms, 11=1 s
freq_o  out  CH_NUM*DIG_WIDTH*4  latched BCD edge counts; channel c at bits [c*DIG_WIDTH*4 +: DIG_WIDTH*4]
ovf_o  out  CH_NUM  latched per-channel overflow flag
gate_sel_o  out  2  gate_sel value used for the currently latched results (Hz = count * 10^gate_sel_o, with 11 treated as 00)
valid_o  out  1  one-cycle pulse when freq_o/ovf_o/gate_sel_o update
gate_o  out  1  high while the gate window is open

Behaviour:
- Reset: all outputs 0. FSM to CLEAR. Synchronisers, edge registers and counters cleared.
- Input path per channel:
  - SYNC_STAGES-flop synchroniser, then one edge register.
  - edge = sync & ~prev.
  - Edge visible SYNC_STAGES+1 cycles after the input transition.
  - Measurable range is below CLK_FREQ_HZ/2 (input high and low each at least 1 clk).
- FSM states:
  - CLEAR (1 cycle): zero all BCD counters and overflow flags; latch gate_sel_i into gate_sel_q; load the gate counter with GATE_N-1. Next state GATE.
  - GATE (exactly GATE_N cycles, gate_o=1): count edges. GATE_N = CLK_FREQ_HZ, CLK_FREQ_HZ/10 or CLK_FREQ_HZ/100 per gate_sel_q. When the gate counter reaches 0, go to LOCK.
  - LOCK (1 cycle): copy counters to freq_o, flags to ovf_o, gate_sel_q to gate_sel_o; valid_o=1. Next state CLEAR.
- Measurement period is GATE_N+2 cycles and runs continuously.
- Edge counting rules:
  - An edge asserted in a GATE cycle increments that channel by 1.
  - Edges in CLEAR or LOCK are discarded.
- BCD arithmetic:
  - Digit 9 rolls to 0 with a carry to the next digit.
  - When all digits are 9 and another edge arrives, the counter holds all-9s and the channel overflow flag is set.
  - The overflow flag stays set until the next CLEAR.
- gate_sel_i changes mid-window are ignored until the next CLEAR.
- Reset asserted mid-window aborts the window. Outputs return to 0, and the first valid_o follows a complete fresh window.
- Outputs are registered and change only in the LOCK cycle, so they are stable for GATE_N+1 cycles between valid_o pulses.
- Gate counter width: $clog2(CLK_FREQ_HZ).

Optional Feature:
FREQ_METER_HOLD_EN:
- Defined:
  - Adds input port hold_i (1 bit).
  - When hold_i=1 in the LOCK cycle, freq_o/ovf_o/gate_sel_o keep their previous values and valid_o stays 0.
  - Measurement windows continue unaffected.
- Undefined: no hold_i port; every LOCK updates the outputs.

Test Plan:
- CLK_FREQ_HZ=1000, gate_sel=00, ch0 toggling every 5 clk (period 10) -> after 1002 cycles valid_o pulses; ch0 field=0x00000100, ovf_o[0]=0, gate_sel_o=00.
- Same stimulus, gate_sel=10 -> gate_o high for 10 cycles; ch0 field=0x00000001 (±1 depending on phase), gate_sel_o=10. Change gate_sel mid-window -> the current window keeps its length, and the new length applies from the next window.
- DIG_WIDTH=2, ch1 period 4 clk, gate 1000 cycles (250 edges) -> ch1 field=0x99, ovf_o[1]=1. The next window with ch1 idle gives 0x00 and ovf=0.
- All channels driven at distinct periods 4/6/8/10 clk simultaneously -> ch0..ch3 = 250/166-167/125/100 in BCD, with no cross-channel interference.
- Assert rst for 3 cycles at cycle 500 of a window -> all outputs 0 immediately. The next valid_o arrives exactly GATE_N+2 cycles after rst deassertion, carrying a complete fresh count.
- With FREQ_METER_HOLD_EN, hold_i=1 across a LOCK -> no valid_o and freq_o unchanged. With hold_i=0, the next LOCK updates normally.
